// File: rtl/stack_pkg.sv
// Shared encodings for the operand stack: command opcodes and control FSM states.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

endpackage

// File: rtl/stack_ram_array.sv
// Spill storage for stack entries below NEXT: synchronous write, registered read.
module stack_ram_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 126,
  parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset; the engine never reads an unwritten slot.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/stack_engine.sv
// Operand stack with TOP/NEXT held in registers and deeper entries spilled to RAM;
// a POP of three or more entries takes one extra cycle to refill NEXT from RAM.
module stack_engine
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cs,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_clr_err,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_top,
  output logic [DATA_W-1:0] o_next,
  output logic [ADDR_W:0]   o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_ovf,
  output logic              o_unf
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned RAM_DEPTH = DEPTH - 2;
  localparam int unsigned RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  localparam logic [CNT_W-1:0] C_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_THREE = CNT_W'(3);
  localparam logic [CNT_W-1:0] C_FULL  = CNT_W'(DEPTH);

  state_e            r_state, w_state;
  logic [DATA_W-1:0] r_top, w_top;
  logic [DATA_W-1:0] r_next, w_next;
  logic [CNT_W-1:0]  r_count, w_count;
  logic              r_ready, r_empty, r_full;
  logic              r_ovf, w_ovf;
  logic              r_unf, w_unf;

  logic              w_take;
  op_e               w_op;
  logic              w_we;
  logic [RAM_AW-1:0] w_waddr;
  logic [RAM_AW-1:0] w_raddr;
  logic [DATA_W-1:0] w_rdata;

  stack_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (RAM_DEPTH),
    .ADDR_W (RAM_AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (r_next),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_op    = op_e'(i_op);
  assign w_take  = i_cs && (r_state == ST_IDLE) && (w_op != OP_NOP);
  assign w_waddr = RAM_AW'(r_count - C_TWO);
  // The read is launched on every edge; only the one coinciding with a deep POP is consumed.
  assign w_raddr = (r_count >= C_THREE) ? RAM_AW'(r_count - C_THREE) : RAM_AW'(0);

  // Next-state, datapath and flag update.
  always_comb begin
    w_state = r_state;
    w_top   = r_top;
    w_next  = r_next;
    w_count = r_count;
    w_we    = 1'b0;
    w_ovf   = r_ovf & ~i_clr_err;
    w_unf   = r_unf & ~i_clr_err;

    unique case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          unique case (w_op)
            OP_PUSH: begin
              if (r_count == C_FULL) begin
                w_ovf = 1'b1;
              end else begin
                w_we    = (r_count >= C_TWO);
                w_next  = r_top;
                w_top   = i_data_in;
                w_count = r_count + C_ONE;
              end
            end
            OP_POP: begin
              if (r_count == C_ZERO) begin
                w_unf = 1'b1;
              end else if (r_count == C_ONE) begin
                w_top   = '0;
                w_next  = '0;
                w_count = C_ZERO;
              end else if (r_count == C_TWO) begin
                w_top   = r_next;
                w_next  = '0;
                w_count = C_ONE;
              end else begin
                w_top   = r_next;
                w_count = r_count - C_ONE;
                w_state = ST_REFILL;
              end
            end
            OP_REPLACE: begin
              if (r_count == C_ZERO) begin
                w_unf = 1'b1;
              end else begin
                w_top = i_data_in;
              end
            end
            default: ;
          endcase
        end
      end
      ST_REFILL: begin
        w_next  = w_rdata;
        w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  // State register; status outputs are registered from the next-state values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_top   <= '0;
      r_next  <= '0;
      r_count <= C_ZERO;
      r_ready <= 1'b1;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_top   <= w_top;
      r_next  <= w_next;
      r_count <= w_count;
      r_ready <= (w_state == ST_IDLE);
      r_empty <= (w_count == C_ZERO);
      r_full  <= (w_count == C_FULL);
      r_ovf   <= w_ovf;
      r_unf   <= w_unf;
    end
  end

  assign o_ready = r_ready;
  assign o_top   = r_top;
  assign o_next  = r_next;
  assign o_count = r_count;
  assign o_empty = r_empty;
  assign o_full  = r_full;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;

endmodule

// File: tb/tb_stack_engine.sv
// Directed bench for stack_engine (DEPTH=4): a queue-based reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_stack_engine;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP = 2'b10;
  localparam logic [1:0] REPL = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cs = 1'b0;
  logic [1:0]        op = 2'b00;
  logic [DATA_W-1:0] din = '0;
  logic              clr = 1'b0;
  logic              ready, empty, full, ovf, unf;
  logic [DATA_W-1:0] top, dut_next;
  logic [ADDR_W:0]   count;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  stack_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cs(cs), .i_op(op), .i_data_in(din),
    .i_clr_err(clr), .o_ready(ready), .o_top(top), .o_next(dut_next),
    .o_count(count), .o_empty(empty), .o_full(full), .o_ovf(ovf), .o_unf(unf)
  );

  always #5 clk = ~clk;

  // Reference model: the stack as a queue (last element is TOP).
  int unsigned q[$];
  bit          m_ovf = 0, m_unf = 0, m_busy = 0;
  int unsigned m_stale = 0;
  bit          e_o, e_u;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_busy = 0; m_stale = 0;
    end else begin
      e_o = 0; e_u = 0;
      if (m_busy) begin
        m_busy = 0;
      end else if (cs && op != NOP) begin
        case (op)
          PUSH: if (q.size() == DEPTH) e_o = 1; else q.push_back(int'(din));
          POP: begin
            if (q.size() == 0) e_u = 1;
            else begin
              if (q.size() >= 3) begin
                m_busy  = 1;
                m_stale = q[q.size()-2];
              end
              void'(q.pop_back());
            end
          end
          default: if (q.size() == 0) e_u = 1; else q[q.size()-1] = int'(din);
        endcase
      end
      if (clr) begin m_ovf = 0; m_unf = 0; end
      if (e_o) m_ovf = 1;
      if (e_u) m_unf = 1;
    end
  end

  function automatic int unsigned exp_top();
    return (q.size() > 0) ? q[q.size()-1] : 0;
  endfunction

  function automatic int unsigned exp_next();
    if (m_busy) return m_stale;
    return (q.size() >= 2) ? q[q.size()-2] : 0;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ready", 32'(ready), 32'(!m_busy));
      chk("m_top",   32'(top), exp_top());
      chk("m_next",  32'(dut_next), exp_next());
      chk("m_count", 32'(count), q.size());
      chk("m_empty", 32'(empty), 32'(q.size() == 0));
      chk("m_full",  32'(full), 32'(q.size() == DEPTH));
      chk("m_ovf",   32'(ovf), 32'(m_ovf));
      chk("m_unf",   32'(unf), 32'(m_unf));
    end
  end

  task automatic cmd(input bit c, input logic [1:0] o, input logic [DATA_W-1:0] d, input bit cl);
    @(negedge clk);
    cs = c; op = o; din = d; clr = cl;
    @(posedge clk);
    #1;
    cs = 1'b0; op = NOP; clr = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_top"},   32'(top), 0);
    chk({tag, "_next"},  32'(dut_next), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"},  32'(full), 0);
    chk({tag, "_ovf"},   32'(ovf), 0);
    chk({tag, "_unf"},   32'(unf), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100us");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_reset_vals("rst");

    // Three pushes, then a deep POP with its refill cycle.
    cmd(1, PUSH, 8'h11, 0);
    chk("p1_ready", 32'(ready), 1);
    cmd(1, PUSH, 8'h22, 0);
    cmd(1, PUSH, 8'h33, 0);
    chk("p3_top", 32'(top), 32'h33);
    chk("p3_next", 32'(dut_next), 32'h22);
    chk("p3_count", 32'(count), 3);
    chk("p3_ready", 32'(ready), 1);
    cmd(1, POP, 8'h00, 0);
    chk("pop1_top", 32'(top), 32'h22);
    chk("pop1_count", 32'(count), 2);
    chk("pop1_ready", 32'(ready), 0);
    cmd(0, NOP, 8'h00, 0);
    chk("pop2_next", 32'(dut_next), 32'h11);
    chk("pop2_ready", 32'(ready), 1);

    // Short POPs down to empty.
    cmd(1, POP, 8'h00, 0);
    chk("pop_n2_top", 32'(top), 32'h11);
    chk("pop_n2_next", 32'(dut_next), 0);
    cmd(1, POP, 8'h00, 0);
    chk("pop_n1_top", 32'(top), 0);
    chk("pop_n1_empty", 32'(empty), 1);

    // Underflow paths and flag clearing priority.
    cmd(1, POP, 8'h00, 0);
    chk("unf_pop", 32'(unf), 1);
    chk("unf_pop_count", 32'(count), 0);
    cmd(0, NOP, 8'h00, 1);
    chk("unf_clr", 32'(unf), 0);
    cmd(1, REPL, 8'h99, 0);
    chk("unf_repl", 32'(unf), 1);
    chk("unf_repl_top", 32'(top), 0);
    cmd(1, POP, 8'h00, 1);
    chk("unf_set_wins", 32'(unf), 1);
    cmd(0, NOP, 8'h00, 1);

    // Fill past capacity.
    for (int i = 1; i <= 5; i++) cmd(1, PUSH, 8'(i), 0);
    chk("full_count", 32'(count), 4);
    chk("full_full", 32'(full), 1);
    chk("full_ovf", 32'(ovf), 1);
    chk("full_top", 32'(top), 4);
    cmd(0, NOP, 8'h00, 1);
    chk("ovf_clr", 32'(ovf), 0);

    // Second POP lands in the refill cycle and must be ignored.
    cmd(1, POP, 8'h00, 0);
    cmd(1, POP, 8'h00, 0);
    chk("b2b_count", 32'(count), 3);
    chk("b2b_next", 32'(dut_next), 2);
    chk("b2b_unf", 32'(unf), 0);
    cmd(1, POP, 8'h00, 0);
    cmd(0, NOP, 8'h00, 0);
    chk("deep_top", 32'(top), 2);
    chk("deep_next", 32'(dut_next), 1);

    // Deselected POP, then ALU-style replace.
    cmd(0, POP, 8'h00, 0);
    chk("cs0_count", 32'(count), 2);
    chk("cs0_top", 32'(top), 2);
    cmd(1, REPL, 8'h5A, 0);
    chk("repl_top", 32'(top), 32'h5A);
    chk("repl_next", 32'(dut_next), 1);

    // Asynchronous reset in the middle of a refill.
    cmd(1, PUSH, 8'h77, 0);
    cmd(1, POP, 8'h00, 0);
    chk("pre_rst_ready", 32'(ready), 0);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    @(negedge clk);
    rst_n = 1'b1;
    cmd(1, PUSH, 8'hAA, 0);
    chk("post_rst_top", 32'(top), 32'hAA);
    chk("post_rst_count", 32'(count), 1);
    chk("post_rst_next", 32'(dut_next), 0);
    cmd(0, NOP, 8'h00, 0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
